// File: rtl/game_pkg.sv
// Shared game constants: step indices, VGA vertical timing and the frame scheduler state type.
package game_pkg;

  localparam int STEP_PLAYER  = 0;
  localparam int STEP_BULLET  = 1;
  localparam int STEP_DDAVER  = 2;
  localparam int STEP_COLLIDE = 3;
  localparam int NUM_STEPS    = 4;

  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    REQ,
    DONE
  } sched_state_t;

  // Lowest enabled step index at or above 'from'; NUM_STEPS when none remain.
  function automatic logic [2:0] next_step(input logic [NUM_STEPS-1:0] mask, input int from);
    logic [2:0] result;
    result = 3'(NUM_STEPS);
    for (int i = NUM_STEPS - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) result = 3'(i);
    end
    return result;
  endfunction

endpackage

// File: rtl/frame_step_scheduler_if.sv
// Step request/acknowledge handshake plus the per-frame nunchuck snapshot seen by game logic.
interface frame_step_scheduler_if;

  logic [3:0] step_req;
  logic [3:0] step_ack;
  logic [7:0] snap_stick_y;
  logic       snap_z;
  logic       snap_c;

  modport master (
    output step_req,
    output snap_stick_y,
    output snap_z,
    output snap_c,
    input  step_ack
  );

  modport slave (
    input  step_req,
    input  snap_stick_y,
    input  snap_z,
    input  snap_c,
    output step_ack
  );

endinterface

// File: rtl/frame_divider.sv
// Mod-DIV frame counter; is_zero marks the frames on which a divided step runs.
module frame_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic is_zero
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= (cnt == W'(DIV - 1)) ? '0 : cnt + 1'b1;
    end
  end

  assign is_zero = (cnt == '0);

endmodule

// File: rtl/frame_step_scheduler.sv
// Runs the once-per-frame game update steps during vertical blanking and flags overruns/timeouts.
module frame_step_scheduler #(
  parameter int V_ACTIVE    = game_pkg::V_ACTIVE,
  parameter int BULLET_DIV  = 2,
  parameter int DDAVER_DIV  = 30,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    vc,
  input  logic [7:0]                    stick_y,
  input  logic                          z,
  input  logic                          c,
  frame_step_scheduler_if.master        bus,
  output logic [15:0]                   frame_cnt,
  output logic                          busy,
  output logic                          overrun,
  output logic                          timeout
);

  import game_pkg::*;

  localparam int WW = $clog2(ACK_TIMEOUT + 1);

  sched_state_t         state;
  logic [9:0]           prev_vc;
  logic [1:0]           cur;
  logic [NUM_STEPS-1:0] mask;
  logic [NUM_STEPS-1:0] mask_now;
  logic [WW-1:0]        wait_cnt;
  logic                 bullet_zero;
  logic                 ddaver_zero;
  logic                 div_adv;
  logic                 vblank_start;
  logic                 step_acked;
  logic                 wait_expired;
  logic [2:0]           first_step;
  logic [2:0]           nxt;

  assign div_adv      = (state == SNAP);
  assign vblank_start = (vc == 10'(V_ACTIVE)) && (prev_vc != 10'(V_ACTIVE));
  assign mask_now     = {1'b1, ddaver_zero, bullet_zero, 1'b1};
  assign step_acked   = bus.step_ack[cur];
  assign wait_expired = (wait_cnt == WW'(ACK_TIMEOUT - 1));

  always_comb begin
    first_step = next_step(mask_now, 0);
    nxt        = next_step(mask, int'(cur) + 1);
  end

  frame_divider #(.DIV(BULLET_DIV)) u_bullet_div (
    .clk     (clk),
    .rst     (rst),
    .adv     (div_adv),
    .is_zero (bullet_zero)
  );

  frame_divider #(.DIV(DDAVER_DIV)) u_ddaver_div (
    .clk     (clk),
    .rst     (rst),
    .adv     (div_adv),
    .is_zero (ddaver_zero)
  );

  // Snapshot is taken on the accepting edge so a stick change one cycle later cannot leak in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      prev_vc          <= '0;
      cur              <= '0;
      mask             <= '0;
      wait_cnt         <= '0;
      frame_cnt        <= '0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      timeout          <= 1'b0;
      bus.step_req     <= '0;
      bus.snap_stick_y <= '0;
      bus.snap_z       <= 1'b0;
      bus.snap_c       <= 1'b0;
    end else begin
      prev_vc <= vc;
      if (state != IDLE && (vblank_start || vc == '0)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (vblank_start) begin
            state            <= SNAP;
            busy             <= 1'b1;
            frame_cnt        <= frame_cnt + 16'd1;
            bus.snap_stick_y <= stick_y;
            bus.snap_z       <= z;
            bus.snap_c       <= c;
          end
        end
        SNAP: begin
          mask         <= mask_now;
          cur          <= first_step[1:0];
          bus.step_req <= 4'b0001 << first_step[1:0];
          wait_cnt     <= '0;
          state        <= REQ;
        end
        REQ: begin
          if (step_acked || wait_expired) begin
            if (!step_acked) timeout <= 1'b1;
            if (nxt == 3'(NUM_STEPS)) begin
              bus.step_req <= '0;
              state        <= DONE;
            end else begin
              cur          <= nxt[1:0];
              bus.step_req <= 4'b0001 << nxt[1:0];
              wait_cnt     <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
